// File: rtl/barrel_shifter.sv
// Registered rotate-right barrel shifter: y <= a rotated right by amt, built as a log2(WIDTH)-stage mux network.
// Latency: 1 clock from a/amt to y; one result per clock.
// Backpressure: none, the output register loads on every rising edge.
module barrel_shifter #(
    parameter int  WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] y
);

    // stage[k] is the word entering mux level k; stage[SHW] feeds the register.
    logic [SHW:0][WIDTH-1:0] stage;

    assign stage[0] = a;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [WIDTH-1:0] rot;

        // Rotate right by 2^k: the low S bits wrap around to the top.
        assign rot          = {stage[k][S-1:0], stage[k][WIDTH-1:S]};
        assign stage[k+1]   = amt[k] ? rot : stage[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= stage[SHW];
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed-vector bench for barrel_shifter: reset, amount sweep, boundaries, back-to-back, mid-stream reset, exhaustive.
module tb_barrel_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a   = 8'h00;
    logic [2:0] amt = 3'd0;
    logic [7:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    barrel_shifter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .amt   (amt),
        .y     (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [8];

    // Bitwise reference: y[i] = a[(i + amt) mod 8].
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] s);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = d[(i + int'(s)) % 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] da, input logic [2:0] damt);
        @(negedge clk);
        a   = da;
        amt = damt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [2:0] ramt;

        vecs[0] = '{8'b0000_1111, 3'd1, 8'b1000_0111, "sweep_amt1"};
        vecs[1] = '{8'b0000_1111, 3'd2, 8'b1100_0011, "sweep_amt2"};
        vecs[2] = '{8'b0000_1111, 3'd3, 8'b1110_0001, "sweep_amt3"};
        vecs[3] = '{8'b0000_1111, 3'd4, 8'b1111_0000, "sweep_amt4"};
        vecs[4] = '{8'b1011_0010, 3'd0, 8'b1011_0010, "amt0_pass"};
        vecs[5] = '{8'b1000_0000, 3'd7, 8'b0000_0001, "amt7"};
        vecs[6] = '{8'b0000_0001, 3'd1, 8'b1000_0000, "wrap"};
        vecs[7] = '{8'b1001_0110, 3'd5, 8'b1011_0100, "amt5"};

        // Reset asserted before any clock edge.
        rst_n = 1'b1;
        a     = 8'b0000_1111;
        amt   = 3'd1;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_pre_clk", y, 8'h00);
        @(posedge clk); #1;
        check("reset_hold_1", y, 8'h00);
        @(posedge clk); #1;
        check("reset_hold_2", y, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", y, 8'h00);
        @(posedge clk); #1;
        check("release_first", y, 8'b1000_0111);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].a, vecs[i].amt);
            check(vecs[i].name, y, vecs[i].exp);
        end

        // Back-to-back random pairs, new inputs every clock.
        for (int i = 0; i < 256; i++) begin
            ra   = 8'($urandom_range(0, 255));
            ramt = 3'($urandom_range(0, 7));
            apply(ra, ramt);
            check("back_to_back", y, ref_rot(ra, ramt));
        end

        // Mid-stream asynchronous reset.
        apply(8'b0000_1111, 3'd3);
        check("mid_pre", y, 8'b1110_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_clear", y, 8'h00);
        @(posedge clk); #1;
        check("mid_hold", y, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_release_no_edge", y, 8'h00);
        @(posedge clk); #1;
        check("mid_release_first", y, 8'b1110_0001);

        // Exhaustive a x amt.
        for (int ia = 0; ia < 256; ia++) begin
            for (int is = 0; is < 8; is++) begin
                apply(8'(ia), 3'(is));
                check("exhaustive", y, ref_rot(8'(ia), 3'(is)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
